// File: rtl/w_stage_grf.sv
// Write-back stage and 32x32 general register file: selects the write-back value,
// commits it on the clock edge, serves two bypassed read ports and counts retirements.
module w_stage_grf #(
  parameter bit          BYPASS = 1'b1,
  parameter int unsigned CNT_W  = 32,
  parameter bit          TRACE  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      INSTR_W,
  input  logic [4:0]       RegWrite_W,
  input  logic [31:0]      ALUOUT_W,
  input  logic [31:0]      DMOUT_W,
  input  logic [31:0]      PC4_W,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [31:0]      RD1,
  output logic [31:0]      RD2,
  output logic [31:0]      WD_W,
  output logic             wb_en,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [5:0]  OP_JAL   = 6'b000011;
  localparam logic [5:0]  FN_JALR  = 6'b001001;

  logic [XLEN-1:0] grf [NREG];
  logic [5:0]      opcode;
  logic [5:0]      funct;

  assign opcode = INSTR_W[31:26];
  assign funct  = INSTR_W[5:0];

  // Write-back source: load data, link address (PC+8), or ALU result
  always_comb begin
    WD_W = ALUOUT_W;
    if (opcode == OP_LW) begin
      WD_W = DMOUT_W;
    end else if ((opcode == OP_JAL) || ((opcode == OP_RTYPE) && (funct == FN_JALR))) begin
      WD_W = PC4_W + XLEN'(4);
    end
  end

  assign wb_en = (RegWrite_W != 5'd0) && !reset;

  // Register array; entry 0 is cleared on reset and never written afterwards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        grf[i] <= '0;
      end
    end else if (wb_en) begin
      grf[RegWrite_W] <= WD_W;
    end
  end

  // Read ports: $0 is hard zero, otherwise a same-cycle write takes priority
  always_comb begin
    RD1 = grf[A1];
    if (A1 == 5'd0) begin
      RD1 = '0;
    end else if (BYPASS && wb_en && (A1 == RegWrite_W)) begin
      RD1 = WD_W;
    end
  end

  always_comb begin
    RD2 = grf[A2];
    if (A2 == 5'd0) begin
      RD2 = '0;
    end else if (BYPASS && wb_en && (A2 == RegWrite_W)) begin
      RD2 = WD_W;
    end
  end

  // Retired counter: every non-bubble instruction reaching W, stores and branches included
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired <= '0;
    end else if (INSTR_W != 32'd0) begin
      retired <= retired + CNT_W'(1);
    end
  end

  generate
    if (TRACE) begin : g_trace
      always @(posedge clk) begin
        if (wb_en) begin
          $write("@%h: $%d <= %h\n", PC4_W - XLEN'(4), RegWrite_W, WD_W);
        end
      end
    end
  endgenerate

endmodule
